// File: rtl/pipe_skid_reg_if.sv
// ============================================================================
// pipe_skid_reg_if : valid/ready/data handshake bundle for one pipeline hop
// Revision         : 1.0
// ============================================================================
`default_nettype none

interface pipe_skid_reg_if #(
  parameter int DATA_W = 165
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// pipe_skid_reg : valid/ready stage register with two-entry skid, flush and
//                 saturating back-pressure counter
// Revision      : 1.0
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
  parameter int DATA_W       = 165,
  parameter int ZERO_INVALID = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_skid_reg_if.slave   up,
  pipe_skid_reg_if.master  dn,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  // State encoding is {s_v, m_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_data_nxt;
  logic [DATA_W-1:0] s_data;
  logic [DATA_W-1:0] s_data_nxt;
  logic              in_ready_q;
  logic              m_v;
  logic              s_v;
  logic              in_fire;
  logic              out_fire;

  assign m_v       = state[0];
  assign s_v       = state[1];
  assign in_fire   = up.valid & in_ready_q;
  assign out_fire  = m_v & dn.ready;
  assign up.ready  = in_ready_q;
  assign dn.valid  = m_v;
  assign occupancy = {1'b0, m_v} + {1'b0, s_v};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      m_data     <= '0;
      s_data     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      m_data     <= m_data_nxt;
      s_data     <= s_data_nxt;
      // Ready is precomputed from the next skid state so it leaves a flop directly.
      in_ready_q <= ~state_nxt[1];
    end
  end

  always_comb begin
    state_nxt  = state;
    m_data_nxt = m_data;
    s_data_nxt = s_data;
    if (flush) begin
      state_nxt  = EMPTY;
      m_data_nxt = '0;
      s_data_nxt = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt  = ONE;
            m_data_nxt = up.data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_data_nxt = up.data;
          end else if (in_fire) begin
            state_nxt  = FULL;
            s_data_nxt = up.data;
          end else if (out_fire) begin
            state_nxt  = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt  = ONE;
            m_data_nxt = s_data;
            s_data_nxt = '0;
          end
        end
        default: begin
          state_nxt  = EMPTY;
          m_data_nxt = '0;
          s_data_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (m_v && !dn.ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  generate
    if (ZERO_INVALID != 0) begin : g_zero_invalid
      assign dn.data = m_v ? m_data : '0;
    end else begin : g_stale_data
      assign dn.data = m_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// tb_pipe_skid_reg : directed vector bench for pipe_skid_reg
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

  localparam int DW = 165;
  localparam int CW = 3;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          flush     = 1'b0;
  logic          stall_clr = 1'b0;
  logic [1:0]    occ_a;
  logic [1:0]    occ_b;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  int            n_vec = 0;
  int            n_err = 0;

  pipe_skid_reg_if #(.DATA_W(DW)) up_a ();
  pipe_skid_reg_if #(.DATA_W(DW)) dn_a ();
  pipe_skid_reg_if #(.DATA_W(DW)) up_b ();
  pipe_skid_reg_if #(.DATA_W(DW)) dn_b ();

  pipe_skid_reg #(.DATA_W(DW), .ZERO_INVALID(1), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .up(up_a), .dn(dn_a),
    .occupancy(occ_a), .stall_cnt(cnt_a), .stall_clr(stall_clr)
  );

  pipe_skid_reg #(.DATA_W(DW), .ZERO_INVALID(0), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .up(up_b), .dn(dn_b),
    .occupancy(occ_b), .stall_cnt(cnt_b), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic        eov;
    logic [15:0] eod;
    logic [15:0] eodb;
    logic        eir;
    logic [1:0]  eocc;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [15:0] d, input logic ordy,
                     input logic fl, input logic clr, input logic eov,
                     input logic [15:0] eod, input logic [15:0] eodb,
                     input logic eir, input logic [1:0] eocc, input logic [2:0] ecnt);
    vec_t t;
    t.v = v; t.d = d; t.ordy = ordy; t.fl = fl; t.clr = clr;
    t.eov = eov; t.eod = eod; t.eodb = eodb; t.eir = eir; t.eocc = eocc; t.ecnt = ecnt;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic clr);
    up_a.valid = v;    up_b.valid = v;
    up_a.data  = d;    up_b.data  = d;
    dn_a.ready = ordy; dn_b.ready = ordy;
    flush      = fl;
    stall_clr  = clr;
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic clr);
    drive(v, d, ordy, fl, clr);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && dut_a.s_v && !dut_a.m_v) begin
      n_err++;
      $display("FAIL illegal_state: got 10 expected not 10");
    end
  end

  initial begin
    //    v  d       or fl clr | ov od      odb     ir occ cnt
    // streaming
    add(1, 16'h1,  1, 0, 0,   1, 16'h1,  16'h1,  1, 1, 0);
    add(1, 16'h2,  1, 0, 0,   1, 16'h2,  16'h2,  1, 1, 0);
    add(1, 16'h3,  1, 0, 0,   1, 16'h3,  16'h3,  1, 1, 0);
    add(1, 16'h4,  1, 0, 0,   1, 16'h4,  16'h4,  1, 1, 0);
    add(0, 16'h0,  1, 0, 0,   0, 16'h0,  16'h4,  1, 0, 0);
    // skid fill and drain
    add(1, 16'h11, 0, 0, 0,   1, 16'h11, 16'h11, 1, 1, 0);
    add(1, 16'h22, 0, 0, 0,   1, 16'h11, 16'h11, 0, 2, 1);
    add(1, 16'h33, 0, 0, 0,   1, 16'h11, 16'h11, 0, 2, 2);
    add(1, 16'h33, 1, 0, 0,   1, 16'h22, 16'h22, 1, 1, 2);
    add(1, 16'h33, 1, 0, 0,   1, 16'h33, 16'h33, 1, 1, 2);
    add(0, 16'h0,  1, 0, 0,   0, 16'h0,  16'h33, 1, 0, 2);
    // flush from FULL discards concurrent input
    add(1, 16'h55, 0, 0, 0,   1, 16'h55, 16'h55, 1, 1, 2);
    add(1, 16'h66, 0, 0, 0,   1, 16'h55, 16'h55, 0, 2, 3);
    add(1, 16'h44, 0, 1, 0,   0, 16'h0,  16'h0,  1, 0, 4);
    add(0, 16'h0,  1, 0, 0,   0, 16'h0,  16'h0,  1, 0, 4);
    add(1, 16'h77, 1, 1, 0,   0, 16'h0,  16'h0,  1, 0, 4);
    // counter saturation and clear
    add(1, 16'h88, 0, 0, 0,   1, 16'h88, 16'h88, 1, 1, 4);
    add(0, 16'h0,  0, 0, 0,   1, 16'h88, 16'h88, 1, 1, 5);
    add(0, 16'h0,  0, 0, 0,   1, 16'h88, 16'h88, 1, 1, 6);
    add(0, 16'h0,  0, 0, 0,   1, 16'h88, 16'h88, 1, 1, 7);
    add(0, 16'h0,  0, 0, 0,   1, 16'h88, 16'h88, 1, 1, 7);
    add(0, 16'h0,  0, 0, 0,   1, 16'h88, 16'h88, 1, 1, 7);
    add(0, 16'h0,  0, 0, 1,   1, 16'h88, 16'h88, 1, 1, 0);
    add(0, 16'h0,  0, 0, 0,   1, 16'h88, 16'h88, 1, 1, 1);
    add(0, 16'h0,  1, 0, 1,   0, 16'h0,  16'h88, 1, 0, 0);

    // reset held with live input
    drive(1'b1, DW'(16'hABCD), 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", DW'(dn_a.valid), DW'(0));
    check("rst out_data", dn_a.data, '0);
    check("rst stale out_data", dn_b.data, '0);
    check("rst in_ready", DW'(up_a.ready), DW'(1));
    check("rst occupancy", DW'(occ_a), DW'(0));
    check("rst stall_cnt", DW'(cnt_a), DW'(0));

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("first accept valid", DW'(dn_a.valid), DW'(1));
    check("first accept data", dn_a.data, DW'(16'hABCD));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("first drain valid", DW'(dn_a.valid), DW'(0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, DW'(tbl[i].d), tbl[i].ordy, tbl[i].fl, tbl[i].clr);
      check($sformatf("row%0d out_valid", i), DW'(dn_a.valid), DW'(tbl[i].eov));
      check($sformatf("row%0d out_data", i), dn_a.data, DW'(tbl[i].eod));
      check($sformatf("row%0d stale out_data", i), dn_b.data, DW'(tbl[i].eodb));
      check($sformatf("row%0d in_ready", i), DW'(up_a.ready), DW'(tbl[i].eir));
      check($sformatf("row%0d occupancy", i), DW'(occ_a), DW'(tbl[i].eocc));
      check($sformatf("row%0d stall_cnt", i), DW'(cnt_a), DW'(tbl[i].ecnt));
    end

    // asynchronous reset while FULL
    step(1'b1, DW'(16'h99), 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(16'hAA), 1'b0, 1'b0, 1'b0);
    check("pre-reset occupancy", DW'(occ_a), DW'(2));
    check("pre-reset in_ready", DW'(up_a.ready), DW'(0));
    #2 reset = 1'b0;
    #1;
    check("async out_valid", DW'(dn_a.valid), DW'(0));
    check("async out_data", dn_a.data, '0);
    check("async stale out_data", dn_b.data, '0);
    check("async in_ready", DW'(up_a.ready), DW'(1));
    check("async occupancy", DW'(occ_a), DW'(0));
    check("async stall_cnt", DW'(cnt_a), DW'(0));
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("post-reset out_valid", DW'(dn_a.valid), DW'(0));
    check("post-reset stale out_data", dn_b.data, '0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("post-reset idle valid", DW'(dn_a.valid), DW'(0));
    step(1'b1, DW'(16'hBB), 1'b1, 1'b0, 1'b0);
    check("post-reset accept valid", DW'(dn_a.valid), DW'(1));
    check("post-reset accept data", dn_a.data, DW'(16'hBB));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a saturating back-pressure counter. It replaces the fixed-field, always-advancing stage registers between pipeline stages (e.g. EX→MEM). Stalls propagate one stage per cycle without a combinational ready path. Fields such as Instr, ALUout, RT, A3, PC4 and PC8 are packed by the instantiating stage into one payload bus.

## Interface
- `DATA_W`, default 165: payload width in bits (default = 5×32 + 5 for the EX→MEM field set).
- `ZERO_INVALID`, default 1: when 1, `out_data` reads all-zero whenever `out_valid`=0, so an invalid slot looks like a NOP. When 0, `out_data` holds the stale value.
- `CNT_W`, default 16: width of the stall counter.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous kill of all held entries.
- `in_valid`, input, 1: upstream has a payload.
- `in_ready`, output, 1: this stage accepts a payload this cycle; registered.
- `in_data`, input, DATA_W: upstream payload.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: downstream consumes `out_data` this cycle.
- `out_data`, output, DATA_W: payload to the downstream stage.
- `occupancy`, output, 2: number of held entries, 0..2.
- `stall_cnt`, output, CNT_W: count of back-pressured cycles, saturating.
- `stall_clr`, input, 1: synchronous clear of `stall_cnt`.

## Operation
- Storage: main register (`m_data`, `m_v`) drives the outputs. Skid register (`s_data`, `s_v`) holds overflow.
- `in_fire` = `in_valid` & `in_ready`. `out_fire` = `out_valid` & `out_ready`.
- `in_ready` = !`s_v`, taken directly from a flop. There is no combinational path from `out_ready` to `in_ready`.
- State machine, encoded by {`s_v`,`m_v`}:
  - EMPTY (00)
    - `in_fire` → ONE; `m_data` ← `in_data`.
  - ONE (01)
    - `in_fire` & `out_fire` → ONE; main is replaced by `in_data`.
    - `in_fire` & !`out_ready` → FULL; skid captures `in_data`.
    - !`in_fire` & `out_fire` → EMPTY.
    - Otherwise hold.
  - FULL (11), with `in_ready`=0
    - `out_fire` → ONE; `m_data` ← `s_data` and the skid is cleared.
    - Otherwise hold.
  - State 10 is illegal. It must never occur; the verifier asserts this.
- Ordering is strict FIFO. No payload is duplicated or dropped except on `flush`.
- `flush`=1 has priority over everything else. Next state is EMPTY and `m_data`/`s_data` are zeroed. Any `in_fire` in the same cycle is discarded; the hazard unit kills upstream concurrently.
- `occupancy` = `m_v` + `s_v`.
- `stall_cnt`:
  - Increments each cycle with `out_valid` & !`out_ready`.
  - Saturates at 2^CNT_W−1.
  - `stall_clr` sets it to 0 and has priority over the increment.
  - `flush` does not affect it.
- `out_data`: if `ZERO_INVALID`=1 it is `m_data` gated by `m_v`; otherwise it is `m_data`.

## Timing
- Reset (`reset`=0, asynchronous, takes effect immediately):
  - `m_v`=`s_v`=0, `m_data`=`s_data`=0.
  - `out_valid`=0, `out_data`=0, `in_ready`=1, `occupancy`=0, `stall_cnt`=0.
- Reset deassertion: first state update is on the first rising `clk` with `reset`=1.
- Reset in mid-operation discards all held entries with no partial state.
- Latency: a payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (one cycle), provided the stage was EMPTY or draining.
- Throughput: one payload per cycle while `out_ready`=1.
- Back-pressure:
  - `in_ready` falls one cycle after the first stalled cycle that accepted input (ONE→FULL).
  - `in_ready` rises the cycle after FULL drains.
- Flush asserted at edge N: `out_valid`=0 and `in_ready`=1 after edge N.
- Flush and reset asserted together: reset wins.

## Test plan
- Reset: hold `reset`=0 with `in_valid`=1 and `in_data`=0x…ABCD → `out_valid`=0, `out_data`=0, `in_ready`=1, `occupancy`=0, `stall_cnt`=0. Release reset; first accept occurs at the next edge.
- Streaming: `out_ready`=1, inject payloads 1,2,3,4 on consecutive cycles → `out_data` shows 1,2,3,4 one cycle later each. `occupancy` stays 1 and `in_ready` stays 1.
- Skid fill/drain: `out_ready`=0, inject 0x11 then 0x22 → `occupancy`=2 and `in_ready`=0 while 0x33 is held upstream. Raise `out_ready` → outputs are 0x11, 0x22, 0x33 in order; `stall_cnt` equals the number of stalled cycles.
- Flush priority: in state FULL, assert `flush` with `in_valid`=1 and `in_data`=0x44 → next cycle `out_valid`=0, `occupancy`=0, `in_ready`=1. 0x44 never appears on `out_data`.
- Counter saturation: `CNT_W`=3, `out_valid`=1, `out_ready`=0 for 10 cycles → `stall_cnt` stops at 7. Pulse `stall_clr` → 0. Assert `stall_clr` during a stall cycle → 0, not 1.
- Async reset mid-FULL: drop `reset` between edges → outputs go to reset values immediately, without waiting for `clk`. The old payloads are never emitted after release.
